follower_obstacles: RTL and testbench

- Consumer of the vertical-scroll tick. Holds NUM_SLOTS obstacle boxes and advances all of them by MOVE_AMT on every move_followers pulse.
- Wraps each slot at the screen bottom and respawns it at the top with a pseudo-random x position.
- Gives the VGA pixel path a registered obstacle_on pixel flag.
- Detects player/obstacle overlap and freezes the field on a crash.

---
 rtl/follower_obstacles_if.sv | 22 ++
 rtl/follower_obstacles.sv | 146 ++++++++++++++
 tb/tb_follower_obstacles.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/follower_obstacles_if.sv
// Bus between the scroll/VGA side and the obstacle field: move pulse, pixel
// and player coordinates in; pixel flag and crash status out.
interface follower_obstacles_if;
    logic       move_followers;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       obstacle_on;
    logic       collision;
    logic [1:0] hit_slot;

    modport master (
        output move_followers, hpos, vpos, player_x, player_y,
        input  obstacle_on, collision, hit_slot
    );

    modport slave (
        input  move_followers, hpos, vpos, player_x, player_y,
        output obstacle_on, collision, hit_slot
    );
endinterface

// File: rtl/follower_obstacles.sv
// Falling obstacle field: scrolls NUM_SLOTS boxes down on each move pulse,
// respawns them at the top with LFSR x positions, draws them and detects crashes.
module follower_obstacles #(
    parameter int         NUM_SLOTS     = 4,
    parameter int         MOVE_AMT      = 2,
    parameter int         SCREEN_HEIGHT = 480,
    parameter int         SCREEN_WIDTH  = 640,
    parameter int         OBS_W         = 32,
    parameter int         OBS_H         = 16,
    parameter int         SPAWN_GAP     = 120,
    parameter int         PLAYER_W      = 16,
    parameter int         PLAYER_H      = 16,
    parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
    input  logic                 clk,
    input  logic                 reset,
    follower_obstacles_if.slave  bus
);
    localparam logic [10:0] MOVE_WIDE     = 11'(MOVE_AMT);
    localparam logic [10:0] HEIGHT_WIDE   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] X_MAX_WIDE    = 11'(SCREEN_WIDTH - OBS_W);
    localparam logic [10:0] OBS_W_WIDE    = 11'(OBS_W);
    localparam logic [10:0] OBS_H_WIDE    = 11'(OBS_H);
    localparam logic [10:0] PLAYER_W_WIDE = 11'(PLAYER_W);
    localparam logic [10:0] PLAYER_H_WIDE = 11'(PLAYER_H);

    typedef enum logic {RUN, CRASHED} state_t;

    state_t               state, state_next;
    logic                 advance, latch_hit;

    logic [9:0]           slot_x  [NUM_SLOTS];
    logic [9:0]           slot_y  [NUM_SLOTS];
    logic [9:0]           lfsr;

    logic [10:0]          y_sum   [NUM_SLOTS];
    logic [9:0]           x_moved [NUM_SLOTS];
    logic [9:0]           y_moved [NUM_SLOTS];
    logic [9:0]           lfsr_walk;

    logic [NUM_SLOTS-1:0] pix_hit;
    logic [NUM_SLOTS-1:0] player_hit;
    logic                 hit_any;
    logic [1:0]           hit_idx;

    logic                 obstacle_on_q;
    logic [1:0]           hit_slot_q;

    function automatic logic [9:0] lfsr_step(input logic [9:0] r);
        return {r[8:0], r[9] ^ r[6]};
    endfunction

    // Values past the right edge fold back by 512 so every box stays on screen.
    function automatic logic [9:0] spawn_x(input logic [9:0] v);
        return ({1'b0, v} <= X_MAX_WIDE) ? v : v - 10'd512;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        latch_hit  = 1'b0;
        case (state)
            RUN: begin
                advance   = bus.move_followers;
                latch_hit = hit_any;
                if (hit_any) state_next = CRASHED;
            end
            CRASHED: state_next = CRASHED;
            default: state_next = RUN;
        endcase
    end

    // Respawning slots consume LFSR steps in ascending slot order.
    always_comb begin
        lfsr_walk = lfsr;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            y_sum[i] = {1'b0, slot_y[i]} + MOVE_WIDE;
            if (y_sum[i] >= HEIGHT_WIDE) begin
                y_moved[i] = 10'(y_sum[i] - HEIGHT_WIDE);
                lfsr_walk  = lfsr_step(lfsr_walk);
                x_moved[i] = spawn_x(lfsr_walk);
            end else begin
                y_moved[i] = y_sum[i][9:0];
                x_moved[i] = slot_x[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pix_hit[i] = ({1'b0, bus.hpos} >= {1'b0, slot_x[i]}) &&
                         ({1'b0, bus.hpos} <  {1'b0, slot_x[i]} + OBS_W_WIDE) &&
                         ({1'b0, bus.vpos} >= {1'b0, slot_y[i]}) &&
                         ({1'b0, bus.vpos} <  {1'b0, slot_y[i]} + OBS_H_WIDE);
            player_hit[i] = ({1'b0, bus.player_x} < {1'b0, slot_x[i]} + OBS_W_WIDE) &&
                            ({1'b0, slot_x[i]} < {1'b0, bus.player_x} + PLAYER_W_WIDE) &&
                            ({1'b0, bus.player_y} < {1'b0, slot_y[i]} + OBS_H_WIDE) &&
                            ({1'b0, slot_y[i]} < {1'b0, bus.player_y} + PLAYER_H_WIDE);
        end
    end

    always_comb begin
        hit_any = |player_hit;
        hit_idx = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (player_hit[i]) hit_idx = 2'(i);
        end
    end

    // NOTE: slot positions are a handful of flops, not a RAM, so they are
    // reset explicitly to give a deterministic starting field.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_y[i] <= 10'(i * SPAWN_GAP);
                slot_x[i] <= 10'(i * 160 + 64);
            end
            lfsr          <= LFSR_SEED;
            obstacle_on_q <= 1'b0;
            hit_slot_q    <= 2'd0;
        end else begin
            obstacle_on_q <= |pix_hit;
            if (advance) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slot_y[i] <= y_moved[i];
                    slot_x[i] <= x_moved[i];
                end
                lfsr <= lfsr_walk;
            end
            if (latch_hit) hit_slot_q <= hit_idx;
        end
    end

    assign bus.obstacle_on = obstacle_on_q;
    assign bus.collision   = (state == CRASHED);
    assign bus.hit_slot    = hit_slot_q;
endmodule

// File: tb/tb_follower_obstacles.sv
// Bench for follower_obstacles: directed pixel table, hand-written corner
// sequences and a randomized run against an arithmetic model of the field.
module tb_follower_obstacles;
    logic clk = 1'b0;
    logic reset;

    follower_obstacles_if ifc ();

    follower_obstacles dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hpos;
        int vpos;
        bit exp_on;
    } pix_vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the field
    int m_y [4];
    int m_x [4];
    int m_lfsr;
    int m_hit;
    bit m_crash;
    bit m_obs;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int lfsr_next(input int r);
        int fb;
        fb = ((r / 512) + (r / 64)) % 2;
        return ((r * 2) % 1024) + fb;
    endfunction

    function automatic int respawn_x(input int v);
        return (v <= 640 - 32) ? v : v - 512;
    endfunction

    function automatic bit overlap(input int ax, input int ay, input int aw, input int ah,
                                   input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    task automatic model_edge();
        bit obs_next;
        int hit;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_y[i] = i * 120;
                m_x[i] = i * 160 + 64;
            end
            m_lfsr  = 'h2A5;
            m_crash = 0;
            m_hit   = 0;
            m_obs   = 0;
            return;
        end
        obs_next = 0;
        for (int i = 0; i < 4; i++)
            if (overlap(int'(ifc.hpos), int'(ifc.vpos), 1, 1, m_x[i], m_y[i], 32, 16))
                obs_next = 1;
        if (!m_crash) begin
            hit = -1;
            for (int i = 0; i < 4; i++)
                if (hit < 0 && overlap(int'(ifc.player_x), int'(ifc.player_y), 16, 16,
                                       m_x[i], m_y[i], 32, 16))
                    hit = i;
            if (ifc.move_followers) begin
                for (int i = 0; i < 4; i++) begin
                    m_y[i] += 2;
                    if (m_y[i] >= 480) begin
                        m_y[i] -= 480;
                        m_lfsr = lfsr_next(m_lfsr);
                        m_x[i] = respawn_x(m_lfsr);
                    end
                end
            end
            if (hit >= 0) begin
                m_crash = 1;
                m_hit   = hit;
            end
        end
        m_obs = obs_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".obstacle_on"}, int'(ifc.obstacle_on), int'(m_obs));
        check({tag, ".collision"},   int'(ifc.collision),   int'(m_crash));
        check({tag, ".hit_slot"},    int'(ifc.hit_slot),    m_hit);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.slot%0d_y", tag, i), int'(dut.slot_y[i]), m_y[i]);
            check($sformatf("%s.slot%0d_x", tag, i), int'(dut.slot_x[i]), m_x[i]);
        end
        check({tag, ".lfsr"}, int'(dut.lfsr), m_lfsr);
    endtask

    task automatic pulse(input int n);
        ifc.move_followers = 1'b1;
        repeat (n) tick();
        ifc.move_followers = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    pix_vec_t pix_table [13];

    initial begin
        pix_table = '{
            '{64,  0,   1'b1}, '{96,  0,   1'b0}, '{63,  0,   1'b0},
            '{95,  15,  1'b1}, '{95,  16,  1'b0}, '{224, 120, 1'b1},
            '{255, 135, 1'b1}, '{256, 135, 1'b0}, '{384, 239, 1'b0},
            '{415, 240, 1'b1}, '{544, 375, 1'b1}, '{576, 376, 1'b0},
            '{0,   0,   1'b0}
        };

        reset              = 1'b1;
        ifc.move_followers = 1'b0;
        ifc.hpos           = 10'd0;
        ifc.vpos           = 10'd0;
        ifc.player_x       = 10'd0;
        ifc.player_y       = 10'd470;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset.slot%0d_y", i), int'(dut.slot_y[i]), i * 120);
            check($sformatf("reset.slot%0d_x", i), int'(dut.slot_x[i]), i * 160 + 64);
        end
        check("reset.lfsr",        int'(dut.lfsr),        'h2A5);
        check("reset.collision",   int'(ifc.collision),   0);
        check("reset.hit_slot",    int'(ifc.hit_slot),    0);
        check("reset.obstacle_on", int'(ifc.obstacle_on), 0);

        // Pixel table against the reset field, one cycle latency
        foreach (pix_table[k]) begin
            ifc.hpos = 10'(pix_table[k].hpos);
            ifc.vpos = 10'(pix_table[k].vpos);
            tick();
            check($sformatf("pix_table[%0d]", k), int'(ifc.obstacle_on), int'(pix_table[k].exp_on));
            check($sformatf("pix_table[%0d].collision", k), int'(ifc.collision), 0);
        end

        // One move pulse
        pulse(1);
        check("move1.slot0_y", int'(dut.slot_y[0]), 2);
        check("move1.slot1_y", int'(dut.slot_y[1]), 122);
        check("move1.slot2_y", int'(dut.slot_y[2]), 242);
        check("move1.slot3_y", int'(dut.slot_y[3]), 362);
        check("move1.slot3_x", int'(dut.slot_x[3]), 544);
        check("move1.lfsr",    int'(dut.lfsr),      'h2A5);

        // 60 pulses total: slot3 wraps and respawns
        pulse(59);
        check("wrap.slot3_y",    int'(dut.slot_y[3]),  0);
        check("wrap.slot3_x",    int'(dut.slot_x[3]),  331);
        check("wrap.lfsr",       int'(dut.lfsr),       'h14B);
        check("wrap.slot0_y",    int'(dut.slot_y[0]),  120);
        check("wrap.collision",  int'(ifc.collision),  0);
        check_model("wrap");

        // Crash right after reset, player over slot0
        ifc.player_x = 10'd70;
        ifc.player_y = 10'd10;
        apply_reset();
        tick();
        check("crash.collision", int'(ifc.collision), 1);
        check("crash.hit_slot",  int'(ifc.hit_slot),  0);
        pulse(5);
        check("crash.slot0_y_frozen", int'(dut.slot_y[0]), 0);
        check("crash.lfsr_frozen",    int'(dut.lfsr),      'h2A5);
        check("crash.collision_held", int'(ifc.collision), 1);
        ifc.player_x = 10'd0;
        ifc.player_y = 10'd470;
        apply_reset();
        check("crash.reset_clears", int'(ifc.collision), 0);
        tick();
        check("crash.stays_clear",  int'(ifc.collision), 0);

        // Move pulse on the detection cycle is still applied, then freezes
        ifc.player_x = 10'd70;
        ifc.player_y = 10'd10;
        apply_reset();
        pulse(4);
        check("crash_move.collision", int'(ifc.collision), 1);
        check("crash_move.slot0_y",   int'(dut.slot_y[0]), 2);
        check_model("crash_move");

        // Reset together with a move pulse during a wrap
        ifc.player_x = 10'd0;
        ifc.player_y = 10'd470;
        apply_reset();
        pulse(59);
        check("pre_wrap.slot3_y", int'(dut.slot_y[3]), 478);
        reset              = 1'b1;
        ifc.move_followers = 1'b1;
        tick();
        reset              = 1'b0;
        ifc.move_followers = 1'b0;
        check("reset_wrap.slot3_y", int'(dut.slot_y[3]), 360);
        check("reset_wrap.slot3_x", int'(dut.slot_x[3]), 544);
        check("reset_wrap.slot0_y", int'(dut.slot_y[0]), 0);
        check("reset_wrap.lfsr",    int'(dut.lfsr),      'h2A5);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            ifc.move_followers = 1'($urandom_range(0, 1));
            ifc.hpos           = 10'($urandom_range(0, 799));
            ifc.vpos           = 10'($urandom_range(0, 524));
            if ($urandom_range(0, 63) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    ifc.player_x = 10'($urandom_range(0, 623));
                    ifc.player_y = 10'($urandom_range(0, 463));
                end else begin
                    ifc.player_x = 10'($urandom_range(0, 15));
                    ifc.player_y = 10'($urandom_range(440, 479));
                end
            end
            reset = (m_crash && $urandom_range(0, 19) == 0) || ($urandom_range(0, 499) == 0);
            tick();
            check_model("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
